// File: rtl/inst_loader.sv
// inst_loader: assembles a little-endian byte stream into 32-bit words and writes them into
// instruction memory, holding the core in reset until the image is in. Trailer checksum: INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  input  logic        restart_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_wready_i,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS + 1);
  localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    ST_CSUM  = 3'd5
`endif
  } state_t;

  // Where the image ends up once the last word (or an empty header) has been handled.
`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
    logic [31:0] wide;
    wide = {{(32-IDX_W){1'b0}}, idx};
    return BASE_ADDR + {wide[29:0], 2'b00};
  endfunction

`ifdef INST_LOADER_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction
`endif

  state_t            state_r;
  state_t            next_state_s;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       asm_r;
  logic [23:0]       asm_next_s;
  logic [31:0]       count_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_next_s;
  logic              last_word_s;
  logic [31:0]       word_s;
  logic              byte_fire_s;
  logic              collect_s;
  logic              group_last_s;
  logic              restart_take_s;
  logic              ready_r;
  logic              mem_we_r;
  logic [31:0]       mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              hold_r;
  logic              done_r;
  logic              err_r;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        csum_r;
`endif

  assign byte_fire_s    = byte_valid_i && ready_r;
  assign collect_s      = byte_fire_s && ((state_r == ST_HDR) || (state_r == ST_DATA));
  assign group_last_s   = collect_s && (byte_cnt_r == 2'd3);
  assign word_s         = {byte_data_i, asm_r};
  assign idx_next_s     = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
  assign last_word_s    = ({{(32-IDX_W){1'b0}}, idx_next_s} == count_r);
  assign restart_take_s = restart_i && ((state_r == ST_DONE) || (state_r == ST_ERR));

  // Byte lane steering for the partially assembled word.
  always_comb begin
    asm_next_s = asm_r;
    case (byte_cnt_r)
      2'd0:    asm_next_s[7:0]   = byte_data_i;
      2'd1:    asm_next_s[15:8]  = byte_data_i;
      2'd2:    asm_next_s[23:16] = byte_data_i;
      default: asm_next_s        = asm_r;
    endcase
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (group_last_s) begin
          if (word_s == 32'h0000_0000) begin
            next_state_s = ST_TAIL;
          end else if (word_s > DEPTH_W32) begin
            next_state_s = ST_ERR;
          end else begin
            next_state_s = ST_DATA;
          end
        end else begin
          next_state_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (group_last_s) begin
          next_state_s = ST_WRITE;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (mem_wready_i) begin
          if (last_word_s) begin
            next_state_s = ST_TAIL;
          end else begin
            next_state_s = ST_DATA;
          end
        end else begin
          next_state_s = ST_WRITE;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_fire_s) begin
          if (byte_data_i == csum_r) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_ERR;
          end
        end else begin
          next_state_s = ST_CSUM;
        end
      end
`endif
      ST_DONE, ST_ERR: begin
        if (restart_i) begin
          next_state_s = ST_HDR;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = ST_ERR;
    endcase
  end

  // State register and state-decoded outputs, registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_HDR;
      ready_r  <= 1'b0;
      mem_we_r <= 1'b0;
      hold_r   <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= next_state_s;
`ifdef INST_LOADER_CHECKSUM_EN
      ready_r  <= (next_state_s == ST_HDR) || (next_state_s == ST_DATA) || (next_state_s == ST_CSUM);
`else
      ready_r  <= (next_state_s == ST_HDR) || (next_state_s == ST_DATA);
`endif
      mem_we_r <= (next_state_s == ST_WRITE);
      hold_r   <= (next_state_s != ST_DONE);
      done_r   <= (next_state_s == ST_DONE);
      err_r    <= (next_state_s == ST_ERR);
    end
  end

  // Byte assembly, word count, write index and the write request payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_r  <= 2'd0;
      asm_r       <= 24'h00_0000;
      count_r     <= 32'h0000_0000;
      idx_r       <= {IDX_W{1'b0}};
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_r      <= 8'h00;
`endif
    end else if (restart_take_s) begin
      byte_cnt_r  <= 2'd0;
      asm_r       <= 24'h00_0000;
      count_r     <= 32'h0000_0000;
      idx_r       <= {IDX_W{1'b0}};
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_r      <= 8'h00;
`endif
    end else begin
      if (collect_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        asm_r      <= group_last_s ? 24'h00_0000 : asm_next_s;
      end
      if (group_last_s && (state_r == ST_HDR)) begin
        count_r <= word_s;
        idx_r   <= {IDX_W{1'b0}};
      end
      // Address and data are captured once and held for the whole write handshake.
      if (group_last_s && (state_r == ST_DATA)) begin
        mem_addr_r  <= word_addr(idx_r);
        mem_wdata_r <= word_s;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_r      <= csum_r ^ xor_bytes(word_s);
`endif
      end
      if ((state_r == ST_WRITE) && mem_wready_i) begin
        idx_r <= idx_next_s;
      end
    end
  end

  assign byte_ready_o = ready_r;
  assign mem_we_o     = mem_we_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_wdata_o  = mem_wdata_r;
  assign cpu_hold_o   = hold_r;
  assign done_o       = done_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: images are built from word lists, expected writes and
// outcome are derived from the image rules, observed writes are collected by a monitor.
module tb_inst_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 4096;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_ready_o;
  logic        restart_i = 1'b0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_wready_i = 1'b1;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  inst_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .restart_i(restart_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wready_i(mem_wready_i),
    .cpu_hold_o(cpu_hold_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: handshake, payload stability during stalls, no byte acceptance while writing.
  logic        stall_prev = 1'b0;
  logic [31:0] addr_prev  = 32'h0;
  logic [31:0] data_prev  = 32'h0;
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev && mem_we_o) begin
        chk("addr_stable", mem_addr_o, addr_prev);
        chk("data_stable", mem_wdata_o, data_prev);
      end
      if (mem_we_o) chk("ready_in_write", 32'(byte_ready_o), 32'd0);
      if (mem_we_o && mem_wready_i) wq.push_back({mem_addr_o, mem_wdata_o});
      stall_prev = mem_we_o && !mem_wready_i;
      addr_prev  = mem_addr_o;
      data_prev  = mem_wdata_o;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // wmode: 0 always ready, 1 random, 2 stall first write 3 cycles, 3 never ready.
  task automatic feed(input byte_q_t img, input int n_words, input int wmode,
                      input int gap_pct, input bit wait_end);
    int i = 0;
    int cyc = 0;
    int stall_left = 3;
    int budget;
    bit fired;
    budget = 8 * img.size() + 200;
    while (cyc < budget) begin
      byte_valid_i = (i < img.size()) && ($urandom_range(99) >= 32'(gap_pct));
      byte_data_i  = (i < img.size()) ? img[i] : 8'h00;
      case (wmode)
        0: mem_wready_i = 1'b1;
        1: mem_wready_i = 1'($urandom_range(1));
        2: begin
          if (mem_we_o && stall_left > 0) begin
            mem_wready_i = 1'b0;
            stall_left--;
          end else begin
            mem_wready_i = 1'b1;
          end
        end
        default: mem_wready_i = 1'b0;
      endcase
      fired = byte_valid_i && byte_ready_o;
      @(posedge clk); #1;
      cyc++;
      if (fired) begin
        if (i >= 4 && i < 4 + 4 * n_words && (i % 4) == 3)
          chk("write_latency", 32'(mem_we_o), 32'd1);
        i++;
      end
      if (i >= img.size() && (!wait_end || done_o || err_o)) break;
    end
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    chk("feed_timeout", 32'(cyc < budget), 32'd1);
  endtask

  task automatic run_case(input string tag, input logic [31:0] n, input word_q_t words,
                          input int wmode, input int gap_pct, input logic [7:0] trailer_flip);
    byte_q_t img;
    logic [7:0] sum = 8'h00;
    bit over;
    bit exp_err;
    int n_wr;
    over    = (n > 32'(DEPTH));
    n_wr    = over ? 0 : int'(n);
    exp_err = over || (CSUM_EN && trailer_flip != 8'h00);
    for (int b = 0; b < 4; b++) img.push_back(n[8*b +: 8]);
    for (int w = 0; w < n_wr; w++) begin
      for (int b = 0; b < 4; b++) begin
        img.push_back(words[w][8*b +: 8]);
        sum ^= words[w][8*b +: 8];
      end
    end
    if (CSUM_EN && !over) img.push_back(sum ^ trailer_flip);
    wq.delete();
    feed(img, n_wr, wmode, gap_pct, 1'b1);
    mem_wready_i = 1'b1;
    chk({tag, ":write_count"}, 32'(wq.size()), 32'(n_wr));
    for (int w = 0; w < n_wr && w < wq.size(); w++) begin
      chk({tag, ":addr"}, wq[w][63:32], BASE + 32'(w) * 32'd4);
      chk({tag, ":data"}, wq[w][31:0], words[w]);
    end
    chk({tag, ":done"}, 32'(done_o), 32'(!exp_err));
    chk({tag, ":err"}, 32'(err_o), 32'(exp_err));
    chk({tag, ":hold"}, 32'(cpu_hold_o), 32'(exp_err));
    chk({tag, ":ready_idle"}, 32'(byte_ready_o), 32'd0);
    restart_i = 1'b1;
    @(posedge clk); #1;
    restart_i = 1'b0;
    chk({tag, ":restart_done"}, 32'(done_o), 32'd0);
    chk({tag, ":restart_err"}, 32'(err_o), 32'd0);
    chk({tag, ":restart_hold"}, 32'(cpu_hold_o), 32'd1);
    chk({tag, ":restart_ready"}, 32'(byte_ready_o), 32'd1);
  endtask

  initial begin
    word_q_t words;
    byte_q_t img;

    #2 rst = 1'b0;
    #10;
    chk("reset_hold", 32'(cpu_hold_o), 32'd1);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_we", 32'(mem_we_o), 32'd0);
    chk("reset_ready", 32'(byte_ready_o), 32'd0);
    chk("reset_addr", mem_addr_o, 32'd0);
    chk("reset_wdata", mem_wdata_o, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("hdr_ready", 32'(byte_ready_o), 32'd1);
    chk("hdr_hold", 32'(cpu_hold_o), 32'd1);

    words = '{32'h0000_0013, 32'h0010_0093};
    run_case("two_words", 2, words, 0, 0, 8'h00);
    run_case("stall", 2, words, 2, 0, 8'h00);
    words.delete();
    run_case("too_big", 32'd4097, words, 0, 0, 8'h00);
    run_case("empty", 0, words, 0, 0, 8'h00);
    words = '{32'h0000_0013};
    run_case("one_word", 1, words, 0, 0, 8'h00);
    run_case("one_word_flip", 1, words, 0, 0, 8'h01);

    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    feed(img, 1, 0, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midload_we", 32'(mem_we_o), 32'd0);
    chk("midload_hold", 32'(cpu_hold_o), 32'd1);
    chk("midload_ready", 32'(byte_ready_o), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    words = '{32'h1234_5678};
    run_case("after_reset", 1, words, 0, 0, 8'h00);

    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    feed(img, 1, 3, 0, 1'b0);
    @(posedge clk); #1;
    chk("stalled_we", 32'(mem_we_o), 32'd1);
    chk("stalled_addr", mem_addr_o, BASE);
    chk("stalled_data", mem_wdata_o, 32'hDEAD_BEEF);
    #2 rst = 1'b0;
    #1;
    chk("rst_drops_we", 32'(mem_we_o), 32'd0);
    @(negedge clk) begin
      rst = 1'b1;
      mem_wready_i = 1'b1;
    end
    @(posedge clk); #1;
    words = '{32'hCAFE_F00D};
    run_case("after_reset2", 1, words, 1, 20, 8'h00);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(8, 1));
      words.delete();
      for (int w = 0; w < n; w++) words.push_back($urandom);
      run_case("random", 32'(n), words, 1, 30, (t == 3) ? 8'h40 : 8'h00);
    end

    words.delete();
    run_case("huge_n", 32'h8000_0001, words, 0, 0, 8'h00);
    for (int w = 0; w < DEPTH; w++) words.push_back($urandom);
    run_case("full_depth", 32'(DEPTH), words, 0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
